// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Iterative 32-bit shift/rotate unit. An accepted start captures the operand,
//   the op and the shift amount. The unit then moves the working value one bit
//   per clock until the amount is used up, and pulses done for one cycle.
//   The final value stays on result until the next accepted start.
//
// Ports
//   clk      in   1   rising-edge clock
//   reset    in   1   synchronous, active-high
//   start    in   1   request, sampled only while idle
//   op       in   3   000 load, 001 SLL, 010 SRL, 011 SRA, 100 ROR, 101 ROL,
//                     110/111 load
//   data_in  in  32   operand
//   amount   in   5   shift count 0..31
//   result   out 32   working/final value (registered)
//   busy     out  1   high whenever not idle (registered)
//   done     out  1   one-cycle completion pulse (registered)
module shift_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] data_in,
  input  logic [4:0]  amount,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b101;

  state_t      state;
  logic [2:0]  op_q;
  logic [4:0]  count;
  logic [4:0]  start_count;
  logic [31:0] step;

  // Load and the unused encodings finish without shifting.
  always_comb begin
    start_count = 5'd0;
    if (op >= OP_SLL && op <= OP_ROL) start_count = amount;
  end

  // One 1-bit step of the captured op.
  always_comb begin
    step = result;
    case (op_q)
      OP_SLL:  step = {result[30:0], 1'b0};
      OP_SRL:  step = {1'b0, result[31:1]};
      OP_SRA:  step = {result[31], result[31:1]};
      OP_ROR:  step = {result[0], result[31:1]};
      OP_ROL:  step = {result[30:0], result[31]};
      default: step = result;
    endcase
  end

  // busy and done are registered next to the state. They are set to the
  // values that match the state being entered, so they behave exactly like
  // decodes of the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= 3'd0;
      count  <= 5'd0;
      result <= 32'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            result <= data_in;
            op_q   <= op;
            count  <= start_count;
            busy   <= 1'b1;
            if (start_count != 5'd0) begin
              state <= SHIFT;
              done  <= 1'b0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          result <= step;
          count  <= count - 5'd1;
          if (count == 5'd1) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Iterative 32-bit shift/rotate unit for the multicycle datapath: accepts an operand, a shift amount and an operation, then shifts one bit position per clock until the amount is exhausted. It is the sequential counterpart of the combinational auxiliary ALU shifter. It covers left/right logical, right arithmetic and both rotate directions, with a start/busy/done handshake toward the control unit. The result is held stable for the register-file write-back stage.

## Interface
- No parameters; width fixed at 32 bits, amount at 5 bits.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- start  input  1  request; sampled only in IDLE
- op  input  3  000 load, 001 SLL, 010 SRL, 011 SRA, 100 ROR, 101 ROL, 110/111 treated as load
- data_in  input  32  operand, captured on accepted start
- amount  input  5  shift count 0..31, captured on accepted start
- result  output  32  working/final value (registered)
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  single-cycle completion pulse

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: if start=1 → result←data_in, op and count←amount captured. For load ops, count is forced to 0. Next state is SHIFT if count≠0, else DONE. start=0 → stay; result holds.
- SHIFT: each edge applies one 1-bit step to result according to the captured op, then count←count−1. On the edge where count=1, go to DONE.
  - SLL: {r[30:0],0}
  - SRL: {0,r[31:1]}
  - SRA: {r[31],r[31:1]}
  - ROR: {r[0],r[31:1]}
  - ROL: {r[30:0],r[31]}
- DONE: done=1 for exactly this cycle; next edge → IDLE unconditionally. result unchanged.
- start while busy=1 (SHIFT or DONE): ignored, not queued. data_in, amount and op changes during operation have no effect.
- result holds its last value in IDLE until the next accepted start.
- reset: state←IDLE, result←0, count←0, busy=0, done=0. Reset asserted mid-operation aborts it with no done pulse. reset has priority over start on the same edge.

## Timing
- Start accepted at edge k with amount N (non-load op): N shift edges k+1..k+N. DONE holds during cycle after edge k+N (N≥1) or after edge k (N=0 or load). IDLE returns one edge later.
- Latency from start-sample cycle to done: N+1 cycles. Earliest next accepted start is at the edge ending the DONE cycle +1 (i.e., first IDLE cycle); back-to-back throughput is N+2 cycles per operation.
- busy rises the cycle after acceptance and falls together with done.
- done and busy are registered-state decodes; no combinational path from any input to any output.
- Final result is valid in the DONE cycle and remains valid until the next accepted start.

## Test plan
- Reset, then op=011 SRA, data_in=0x80000000, amount=4 → done in 5th cycle after start sample, result=0xF8000000, busy high for exactly 5 cycles.
- op=001 SLL, data_in=0x00000001, amount=31 → result=0x80000000, done after 32 cycles; op=010 SRL of 0x80000000 by 31 → 0x00000001.
- op=100 ROR, data_in=0x0000000F, amount=4 → 0xF0000000; op=101 ROL, data_in=0x80000001, amount=1 → 0x00000003.
- amount=0 with op=011, data_in=0x12345678 → done one cycle after start, result=0x12345678; op=000 with amount=7 → same 1-cycle completion, result=data_in.
- During SRL of 0xFFFFFFFF by 8, pulse start with data_in=0 and change amount → ignored; result=0x00FFFFFF, exactly one done pulse.
- Assert reset at the 3rd SHIFT cycle of an SLL by 10 → next cycle result=0, busy=0, no done pulse; subsequent start completes normally.
